qmult_arbiter: RTL and testbench

QMULT_ARBITER -- requirements
Module: qmult_arbiter

---
 rtl/qmult_arbiter.sv | 179 +++++++++++++++++
 tb/tb_qmult_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmult_arbiter.sv
// qmult_arbiter: round-robin front end that shares one serial Q-format
// multiplier between R requesters. A winner's operands are captured and
// handed to the multiplier. The product comes back to that requester as a
// one-cycle o_valid pulse. A watchdog aborts jobs whose multiplier never finishes.
module qmult_arbiter #(
  parameter int Q       = 15,
  parameter int N       = 32,
  parameter int R       = 4,
  parameter int TIMEOUT = 80
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [R-1:0]   i_req,
  input  logic [R*N-1:0] i_multiplicand,
  input  logic [R*N-1:0] i_multiplier,
  output logic [R-1:0]   o_grant,
  output logic [R-1:0]   o_valid,
  output logic [N-1:0]   o_result,
  output logic           o_overflow,
  output logic           o_error,
  output logic           o_busy,
  output logic           o_mult_start,
  output logic [N-1:0]   o_mult_multiplicand,
  output logic [N-1:0]   o_mult_multiplier,
  input  logic [N-1:0]   i_mult_result,
  input  logic           i_mult_complete,
  input  logic           i_mult_overflow
);

  // Q only describes how the multiplier interprets the data; this block moves
  // the bits untouched, so the parameter is only range-checked here.
  if (R < 2 || Q < 0 || Q >= N || TIMEOUT < 1) begin : g_bad_params
    $error("qmult_arbiter: illegal parameter set");
  end

  localparam int PW = $clog2(R);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ACKW  = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t        state_r;
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] owner_r;
  logic [WW-1:0] wdog_r;

  logic          win_found_s;
  logic [PW-1:0] win_idx_s;
  logic [WW-1:0] wdog_inc_s;
  logic          timeout_s;

  // Requester index reached by stepping 'offset' places past 'base', wrapping at R.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % R;
    return PW'(sum);
  endfunction

  // One-hot strobe vector selecting requester 'idx'.
  function automatic logic [R-1:0] onehot(input logic [PW-1:0] idx);
    logic [R-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search: first requesting index at or above ptr_r, modulo R.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < R; i++) begin
      win_idx_s   = (!win_found_s && i_req[rr_index(ptr_r, i)]) ? rr_index(ptr_r, i) : win_idx_s;
      win_found_s = win_found_s | i_req[rr_index(ptr_r, i)];
    end
  end

  // Watchdog expiry: the count after this cycle would hit TIMEOUT.
  always_comb begin
    wdog_inc_s = wdog_r + WW'(1);
    timeout_s  = (wdog_inc_s == WW'(TIMEOUT));
  end

  // Job sequencing FSM; every output is a register written here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r             <= ST_IDLE;
      ptr_r               <= '0;
      owner_r             <= '0;
      wdog_r              <= '0;
      o_grant             <= '0;
      o_valid             <= '0;
      o_result            <= '0;
      o_overflow          <= 1'b0;
      o_error             <= 1'b0;
      o_busy              <= 1'b0;
      o_mult_start        <= 1'b0;
      o_mult_multiplicand <= '0;
      o_mult_multiplier   <= '0;
    end else begin
      // Strobes are single-cycle unless a branch below raises them.
      o_grant      <= '0;
      o_valid      <= '0;
      o_mult_start <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A multiplier that is still busy (e.g. after an abort or a reset
          // of this block only) must not receive a new start.
          if (i_mult_complete && win_found_s) begin
            owner_r             <= win_idx_s;
            ptr_r               <= rr_index(win_idx_s, 1);
            o_grant             <= onehot(win_idx_s);
            o_mult_start        <= 1'b1;
            o_mult_multiplicand <= i_multiplicand[int'(win_idx_s)*N +: N];
            o_mult_multiplier   <= i_multiplier[int'(win_idx_s)*N +: N];
            wdog_r              <= '0;
            o_busy              <= 1'b1;
            state_r             <= ST_START;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_START: begin
          // The start strobe set on entry drops with the default above.
          state_r <= ST_ACKW;
        end
        ST_ACKW: begin
          if (timeout_s) begin
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_error    <= 1'b1;
            o_valid    <= onehot(owner_r);
            state_r    <= ST_RESP;
          end else if (!i_mult_complete) begin
            wdog_r  <= wdog_inc_s;
            state_r <= ST_RUN;
          end else begin
            wdog_r  <= wdog_inc_s;
            state_r <= ST_ACKW;
          end
        end
        ST_RUN: begin
          // A finished product wins over a watchdog expiring in the same cycle.
          if (i_mult_complete) begin
            o_result   <= i_mult_result;
            o_overflow <= i_mult_overflow;
            o_error    <= 1'b0;
            o_valid    <= onehot(owner_r);
            state_r    <= ST_RESP;
          end else if (timeout_s) begin
            o_result   <= '0;
            o_overflow <= 1'b0;
            o_error    <= 1'b1;
            o_valid    <= onehot(owner_r);
            state_r    <= ST_RESP;
          end else begin
            wdog_r  <= wdog_inc_s;
            state_r <= ST_RUN;
          end
        end
        ST_RESP: begin
          o_error <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          o_error <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qmult_arbiter.sv
// Self-checking bench for qmult_arbiter: a behavioural serial multiplier,
// a round-robin reference model and randomized jobs.
module tb_qmult_arbiter;

  localparam int Q       = 15;
  localparam int N       = 32;
  localparam int R       = 4;
  localparam int TIMEOUT = 80;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [R-1:0]   i_req;
  logic [R*N-1:0] i_multiplicand;
  logic [R*N-1:0] i_multiplier;
  logic [R-1:0]   o_grant;
  logic [R-1:0]   o_valid;
  logic [N-1:0]   o_result;
  logic           o_overflow;
  logic           o_error;
  logic           o_busy;
  logic           o_mult_start;
  logic [N-1:0]   o_mult_multiplicand;
  logic [N-1:0]   o_mult_multiplier;
  logic [N-1:0]   i_mult_result = '0;
  logic           i_mult_complete = 1'b1;
  logic           i_mult_overflow = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ptr_m    = 0;
  int mcnt     = 0;
  logic hang   = 1'b0;

  logic [N-1:0] op_a [R];
  logic [N-1:0] op_b [R];

  qmult_arbiter #(.Q(Q), .N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req),
    .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
    .o_grant(o_grant), .o_valid(o_valid), .o_result(o_result),
    .o_overflow(o_overflow), .o_error(o_error), .o_busy(o_busy),
    .o_mult_start(o_mult_start), .o_mult_multiplicand(o_mult_multiplicand),
    .o_mult_multiplier(o_mult_multiplier), .i_mult_result(i_mult_result),
    .i_mult_complete(i_mult_complete), .i_mult_overflow(i_mult_overflow)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always_comb begin
    i_multiplicand = '0;
    i_multiplier   = '0;
    for (int k = 0; k < R; k++) begin
      i_multiplicand[k*N +: N] = op_a[k];
      i_multiplier[k*N +: N]   = op_b[k];
    end
  end

  // Signed-magnitude Q multiply: {overflow, result}.
  function automatic logic [N:0] ref_qmult(input logic [N-1:0] a, input logic [N-1:0] b);
    longint unsigned prod;
    longint unsigned sh;
    logic [N-1:0]    res;
    logic            ovf;
    prod = 64'(a[N-2:0]) * 64'(b[N-2:0]);
    sh   = prod >> Q;
    res  = {a[N-1] ^ b[N-1], sh[N-2:0]};
    ovf  = ((sh >> (N-1)) != 64'd0);
    return {ovf, res};
  endfunction

  // Serial multiplier stand-in: complete drops one edge after start, rises N+1 edges later.
  always @(posedge i_clk) begin
    if (o_mult_start && i_mult_complete) begin
      i_mult_complete <= 1'b0;
      mcnt            <= N;
      {i_mult_overflow, i_mult_result} <= ref_qmult(o_mult_multiplicand, o_mult_multiplier);
    end else if (!i_mult_complete) begin
      if (mcnt == 0) begin
        if (!hang) i_mult_complete <= 1'b1;
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  function automatic int rr_pick(input logic [R-1:0] req, input int ptr);
    for (int i = 0; i < R; i++)
      if (req[(ptr + i) % R]) return (ptr + i) % R;
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    v = $urandom;
    if ($urandom_range(0, 1) == 1) v[N-2:N/2] = '0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Wait for one grant, check it against the model, then wait for its response.
  task automatic serve(input logic drop, input logic scramble, input logic [R-1:0] add_req,
                       input int exp_lat, input logic exp_err, output int who, output int gcyc);
    int           t;
    int           exp_k;
    logic [R-1:0] exp_g;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   ref_v;
    who  = -1;
    gcyc = cyc;
    t    = 0;
    while (o_grant == '0 && t < 400) begin tick(); t++; end
    check("grant_seen", 64'(o_grant != '0), 64'd1);
    if (o_grant == '0) return;
    exp_k = rr_pick(i_req, ptr_m);
    exp_g = '0;
    if (exp_k >= 0) exp_g[exp_k] = 1'b1;
    check("grant", 64'(o_grant), 64'(exp_g));
    for (int k = 0; k < R; k++) if (o_grant[k]) who = k;
    gcyc = cyc;
    if (exp_k < 0) return;
    a = op_a[exp_k];
    b = op_b[exp_k];
    check("mult_start", 64'(o_mult_start), 64'd1);
    check("mult_a", 64'(o_mult_multiplicand), 64'(a));
    check("mult_b", 64'(o_mult_multiplier), 64'(b));
    check("busy", 64'(o_busy), 64'd1);
    ptr_m = (exp_k + 1) % R;
    if (drop) i_req[exp_k] = 1'b0;
    i_req = i_req | add_req;
    if (scramble) begin
      op_a[exp_k] = $urandom;
      op_b[exp_k] = $urandom;
    end
    t = 0;
    while (o_valid == '0 && t < 400) begin tick(); t++; end
    check("valid_seen", 64'(o_valid != '0), 64'd1);
    if (o_valid == '0) return;
    check("latency", 64'(cyc - gcyc), 64'(exp_lat));
    check("valid", 64'(o_valid), 64'(exp_g));
    ref_v = exp_err ? '0 : ref_qmult(a, b);
    check("result", 64'(o_result), 64'(ref_v[N-1:0]));
    check("overflow", 64'(o_overflow), 64'(ref_v[N]));
    check("error", 64'(o_error), 64'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({o_grant, o_valid, o_overflow, o_error, o_busy, o_mult_start}), 64'd0);
    check({tag, "_result"}, 64'(o_result), 64'd0);
    check({tag, "_opa"}, 64'(o_mult_multiplicand), 64'd0);
    check({tag, "_opb"}, 64'(o_mult_multiplier), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int           who;
    int           g;
    int           prev;
    int           t;
    int           gseen;
    int           vseen;
    int           c_rise;
    logic [R-1:0] m;

    i_rst = 1'b1;
    i_req = '0;
    for (int k = 0; k < R; k++) begin op_a[k] = '0; op_b[k] = '0; end
    repeat (3) tick();
    check_all_zero("reset");
    i_rst = 1'b0;

    // Contention straight out of reset: 0,1,2,3 spaced N+5
    for (int k = 0; k < R; k++) begin op_a[k] = rand_op(); op_b[k] = rand_op(); end
    i_req = {R{1'b1}};
    prev  = 0;
    for (int j = 0; j < R; j++) begin
      serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
      check("contend_order", 64'(who), 64'(j));
      if (j > 0) check("contend_spacing", 64'(g - prev), 64'(N+5));
      prev = g;
    end

    // Single known job
    op_a[0] = 32'h0001_8000;
    op_b[0] = 32'h8001_0000;
    i_req   = 4'b0001;
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("single_who", 64'(who), 64'd0);
    check("single_result", 64'(o_result), 64'h8003_0000);
    check("single_ovf", 64'(o_overflow), 64'd0);

    // Overflow
    op_a[2] = 32'h7FFF_FFFF;
    op_b[2] = 32'h7FFF_FFFF;
    i_req   = 4'b0100;
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("ovf_flag", 64'(o_overflow), 64'd1);

    // Random request sets, operands scrambled after grant, random withdrawals
    for (int it = 0; it < 6; it++) begin
      m = R'($urandom_range(1, (1 << R) - 1));
      for (int k = 0; k < R; k++) if (m[k]) begin op_a[k] = rand_op(); op_b[k] = rand_op(); end
      i_req = m;
      prev  = -1;
      while (i_req != '0) begin
        serve(1'b1, 1'b1, '0, N+3, 1'b0, who, g);
        if (who < 0) break;
        if (prev >= 0) check("rand_spacing", 64'(g - prev), 64'(N+5));
        prev = g;
        if ($urandom_range(0, 3) == 0) i_req[$urandom_range(0, R-1)] = 1'b0;
      end
    end

    // Fairness: req1 held, req2 arrives during job 1
    op_a[1] = rand_op(); op_b[1] = rand_op();
    op_a[2] = rand_op(); op_b[2] = rand_op();
    i_req = 4'b0010;
    serve(1'b0, 1'b0, 4'b0100, N+3, 1'b0, who, g);
    check("fair_1st", 64'(who), 64'd1);
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("fair_2nd", 64'(who), 64'd2);
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("fair_3rd", 64'(who), 64'd1);

    // Timeout: multiplier never finishes
    hang    = 1'b1;
    op_a[3] = rand_op(); op_b[3] = rand_op();
    i_req   = 4'b1000;
    serve(1'b1, 1'b0, '0, TIMEOUT+1, 1'b1, who, g);
    check("to_who", 64'(who), 64'd3);
    op_a[0] = rand_op(); op_b[0] = rand_op();
    i_req   = 4'b0001;
    gseen   = 0;
    repeat (20) begin
      tick();
      if (o_grant != '0) gseen++;
    end
    check("to_no_regrant", 64'(gseen), 64'd0);
    hang = 1'b0;
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("to_resume_who", 64'(who), 64'd0);

    // Reset in the middle of RUN
    op_a[2] = rand_op(); op_b[2] = rand_op();
    i_req   = 4'b0100;
    t       = 0;
    while (o_grant == '0 && t < 400) begin tick(); t++; end
    check("midrst_grant", 64'(o_grant), 64'b0100);
    repeat (10) tick();
    i_rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    i_rst = 1'b0;
    ptr_m = 0;
    gseen = 0;
    vseen = 0;
    t     = 0;
    while (!i_mult_complete && t < 200) begin
      tick();
      if (o_grant != '0) gseen++;
      if (o_valid != '0) vseen++;
      t++;
    end
    c_rise = cyc;
    check("midrst_no_grant", 64'(gseen), 64'd0);
    check("midrst_no_valid", 64'(vseen), 64'd0);
    serve(1'b1, 1'b0, '0, N+3, 1'b0, who, g);
    check("midrst_who", 64'(who), 64'd2);
    check("midrst_grant_delay", 64'(g - c_rise), 64'd1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
